timer_ctrl: RTL and testbench

Parametrised countdown-timer controller: the next generation of the PWM project's timer-setting logic. It adds configurable width and limit, pause/resume, clear, hold-to-repeat adjustment, a done pulse, a timed alarm phase and an optional preset reload. It sits between the debounced button conditioner and the display/PWM-off logic. Its count output feeds the digit decoder, and `running` or `alarm` gate the PWM stage.

---
 rtl/timer_pkg.sv | 18 +
 rtl/btn_repeat.sv | 46 ++++
 rtl/timer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================
// timer_pkg: state encoding shared by timer_ctrl and display mux
// Rev 1.0
// ============================================================
package timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// ============================================================
// btn_repeat: rising-edge step with hold-to-repeat on tick_rpt
// Rev 1.0
// ============================================================
module btn_repeat
    import timer_pkg::*;
#(
    parameter int REPEAT_DLY = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic tick_rpt,
    output logic step
);

    localparam int RW = (REPEAT_DLY < 2) ? 1 : $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] c_dly = RW'(REPEAT_DLY);

    logic          r_btn_q;
    logic [RW-1:0] r_hold;
    logic          w_held;
    logic          w_armed;

    assign w_held  = btn & r_btn_q;
    assign w_armed = (r_hold == c_dly);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_btn_q <= btn;
            // hold counter saturates once armed; release re-arms the delay
            if (!w_held)
                r_hold <= '0;
            else if (tick_rpt && !w_armed)
                r_hold <= r_hold + RW'(1);
        end
    end

    assign step = (btn & ~r_btn_q) | (w_held & tick_rpt & w_armed);

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================
// timer_ctrl: countdown timer FSM with pause, alarm and reload
// Rev 1.0
// ============================================================
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W      = 7,
    parameter int MAX_VAL    = 99,
    parameter int REPEAT_DLY = 5,
    parameter int ALARM_SEC  = 3,
    parameter int RELOAD     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_mode,
    input  logic               inc_btn,
    input  logic               dec_btn,
    input  logic               start_btn,
    input  logic               clr_btn,
    input  logic               tick_1hz,
    input  logic               tick_rpt,
    output logic [CNT_W-1:0]   timer_seconds,
    output logic [STATE_W-1:0] state,
    output logic               timer_running,
    output logic               done_pulse,
    output logic               alarm
);

    localparam int AW = (ALARM_SEC < 2) ? 1 : $clog2(ALARM_SEC);
    localparam logic [CNT_W-1:0] c_max_val    = CNT_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [AW-1:0]    c_alarm_last = AW'(ALARM_SEC - 1);

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_count, w_next_count;
    logic [CNT_W-1:0] r_preset, w_next_preset;
    logic [AW-1:0]    r_acnt, w_next_acnt;
    logic             w_next_done;
    logic [3:0]       r_btn_q;
    logic [3:0]       w_edge;
    logic             w_inc_step, w_dec_step;
    logic             w_up, w_dn, w_start, w_clr, w_any_edge;
    logic [CNT_W-1:0] w_exit_count;

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY)) u_inc_rpt (
        .clk      (clk),
        .rst      (rst),
        .btn      (inc_btn),
        .tick_rpt (tick_rpt),
        .step     (w_inc_step)
    );

    btn_repeat #(.REPEAT_DLY(REPEAT_DLY)) u_dec_rpt (
        .clk      (clk),
        .rst      (rst),
        .btn      (dec_btn),
        .tick_rpt (tick_rpt),
        .step     (w_dec_step)
    );

    assign w_edge       = {clr_btn, start_btn, dec_btn, inc_btn} & ~r_btn_q;
    assign w_start      = w_edge[2];
    assign w_clr        = w_edge[3];
    assign w_any_edge   = |w_edge;
    assign w_up         = w_inc_step & ~w_dec_step;
    assign w_dn         = w_dec_step & ~w_inc_step;
    assign w_exit_count = (RELOAD != 0) ? r_preset : '0;

    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_preset = r_preset;
        w_next_acnt   = r_acnt;
        w_next_done   = 1'b0;
        if (!timer_mode) begin
            w_next_state = ST_IDLE;
            w_next_count = '0;
            w_next_acnt  = '0;
        end else if (w_clr) begin
            w_next_state  = ST_IDLE;
            w_next_count  = '0;
            w_next_preset = '0;
            w_next_acnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && (r_count != '0)) begin
                        w_next_state  = ST_RUN;
                        w_next_preset = r_count;
                    end else if (w_up && (r_count < c_max_val)) begin
                        w_next_count = r_count + c_one;
                    end else if (w_dn && (r_count != '0)) begin
                        w_next_count = r_count - c_one;
                    end
                end
                ST_RUN: begin
                    // a tick landing with a start edge still takes its decrement
                    if (tick_1hz) begin
                        if (r_count <= c_one) begin
                            w_next_state = ST_DONE;
                            w_next_count = '0;
                            w_next_done  = 1'b1;
                            w_next_acnt  = '0;
                        end else begin
                            w_next_count = r_count - c_one;
                            if (w_start)
                                w_next_state = ST_PAUSE;
                        end
                    end else if (w_start) begin
                        w_next_state = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_start)
                        w_next_state = ST_RUN;
                    else if (w_up && (r_count < c_max_val))
                        w_next_count = r_count + c_one;
                    else if (w_dn && (r_count > c_one))
                        w_next_count = r_count - c_one;
                end
                ST_DONE: begin
                    if (w_any_edge || (tick_1hz && (r_acnt == c_alarm_last))) begin
                        w_next_state = ST_IDLE;
                        w_next_count = w_exit_count;
                        w_next_acnt  = '0;
                    end else if (tick_1hz) begin
                        w_next_acnt = r_acnt + AW'(1);
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_preset      <= '0;
            r_acnt        <= '0;
            r_btn_q       <= '0;
            done_pulse    <= 1'b0;
            timer_running <= 1'b0;
            alarm         <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_count       <= w_next_count;
            r_preset      <= w_next_preset;
            r_acnt        <= w_next_acnt;
            r_btn_q       <= {clr_btn, start_btn, dec_btn, inc_btn};
            done_pulse    <= w_next_done;
            timer_running <= (w_next_state == ST_RUN);
            alarm         <= (w_next_state == ST_DONE);
        end
    end

    assign timer_seconds = r_count;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================
// tb_timer_ctrl: directed and random stimulus against a per-cycle model
// Rev 1.0
// ============================================================
module tb_timer_ctrl;

    localparam int MAX_VAL    = 99;
    localparam int REPEAT_DLY = 5;
    localparam int ALARM_SEC  = 3;
    localparam int RELOAD     = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       timer_mode = 1'b1;
    logic       inc_btn = 1'b0, dec_btn = 1'b0, start_btn = 1'b0, clr_btn = 1'b0;
    logic       tick_1hz = 1'b0, tick_rpt = 1'b0;
    logic [6:0] timer_seconds;
    logic [1:0] state;
    logic       timer_running, done_pulse, alarm;

    int n_checks = 0;
    int n_pass   = 0;

    // reference: 0 idle, 1 run, 2 pause, 3 done
    int m_state = 0, m_count = 0, m_preset = 0, m_ticks = 0, m_done = 0;
    logic m_prev [4];
    int   m_hold [2];

    always #5 clk = ~clk;

    timer_ctrl #(
        .CNT_W(7), .MAX_VAL(MAX_VAL), .REPEAT_DLY(REPEAT_DLY),
        .ALARM_SEC(ALARM_SEC), .RELOAD(RELOAD)
    ) dut (
        .clk(clk), .rst(rst), .timer_mode(timer_mode),
        .inc_btn(inc_btn), .dec_btn(dec_btn), .start_btn(start_btn), .clr_btn(clr_btn),
        .tick_1hz(tick_1hz), .tick_rpt(tick_rpt),
        .timer_seconds(timer_seconds), .state(state), .timer_running(timer_running),
        .done_pulse(done_pulse), .alarm(alarm)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_clock();
        logic lv [4];
        logic e [4];
        logic stp [2];
        logic held, up, dn, any_e;
        lv[0] = inc_btn; lv[1] = dec_btn; lv[2] = start_btn; lv[3] = clr_btn;
        if (rst) begin
            m_state = 0; m_count = 0; m_preset = 0; m_ticks = 0; m_done = 0;
            for (int i = 0; i < 4; i++) m_prev[i] = 1'b0;
            m_hold[0] = 0; m_hold[1] = 0;
            return;
        end
        for (int i = 0; i < 4; i++) e[i] = lv[i] && !m_prev[i];
        for (int i = 0; i < 2; i++) begin
            held   = lv[i] && m_prev[i];
            stp[i] = e[i] || (held && tick_rpt && m_hold[i] >= REPEAT_DLY);
            if (!lv[i])                m_hold[i] = 0;
            else if (held && tick_rpt) m_hold[i]++;
        end
        for (int i = 0; i < 4; i++) m_prev[i] = lv[i];
        up    = stp[0] && !stp[1];
        dn    = stp[1] && !stp[0];
        any_e = e[0] || e[1] || e[2] || e[3];
        m_done = 0;
        if (!timer_mode) begin
            m_state = 0; m_count = 0; m_ticks = 0;
        end else if (e[3]) begin
            m_state = 0; m_count = 0; m_preset = 0; m_ticks = 0;
        end else if (m_state == 3) begin
            if (tick_1hz) m_ticks++;
            if (m_ticks >= ALARM_SEC || any_e) begin
                m_state = 0; m_count = RELOAD ? m_preset : 0; m_ticks = 0;
            end
        end else if (m_state == 1) begin
            if (tick_1hz) m_count--;
            if (m_count == 0) begin
                m_state = 3; m_done = 1; m_ticks = 0;
            end else if (e[2]) begin
                m_state = 2;
            end
        end else if (m_state == 0) begin
            if (e[2] && m_count > 0) begin
                m_preset = m_count; m_state = 1;
            end else if (up) begin
                m_count = (m_count + 1 > MAX_VAL) ? MAX_VAL : m_count + 1;
            end else if (dn) begin
                m_count = (m_count - 1 < 0) ? 0 : m_count - 1;
            end
        end else begin
            if (e[2])    m_state = 1;
            else if (up) m_count = (m_count + 1 > MAX_VAL) ? MAX_VAL : m_count + 1;
            else if (dn) m_count = (m_count - 1 < 1) ? 1 : m_count - 1;
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        chk("count",   int'(timer_seconds), m_count);
        chk("state",   int'(state), m_state);
        chk("running", int'(timer_running), (m_state == 1) ? 1 : 0);
        chk("alarm",   int'(alarm), (m_state == 3) ? 1 : 0);
        chk("done",    int'(done_pulse), m_done);
    endtask

    task automatic press(input int b);
        case (b)
            0: inc_btn = 1'b1;
            1: dec_btn = 1'b1;
            2: start_btn = 1'b1;
            default: clr_btn = 1'b1;
        endcase
        step();
        inc_btn = 1'b0; dec_btn = 1'b0; start_btn = 1'b0; clr_btn = 1'b0;
        step();
    endtask

    task automatic sec();
        tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
    endtask

    task automatic rpt();
        tick_rpt = 1'b1; step(); tick_rpt = 1'b0; step();
    endtask

    initial begin
        step(); step();
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(timer_seconds), 0);
        rst = 1'b0;

        // basic countdown, alarm and reload
        repeat (3) press(0);
        press(2);
        chk("run_count", int'(timer_seconds), 3);
        chk("run_state", int'(state), 1);
        sec(); sec();
        tick_1hz = 1'b1; step();
        chk("expire_count", int'(timer_seconds), 0);
        chk("expire_state", int'(state), 3);
        chk("expire_pulse", int'(done_pulse), 1);
        tick_1hz = 1'b0; step();
        chk("pulse_width", int'(done_pulse), 0);
        sec(); sec();
        chk("alarm_held", int'(alarm), 1);
        tick_1hz = 1'b1; step();
        chk("reload_state", int'(state), 0);
        chk("reload_count", int'(timer_seconds), 3);
        tick_1hz = 1'b0; step();

        // hold-to-repeat and saturation
        press(3);
        inc_btn = 1'b1; step();
        repeat (20) rpt();
        chk("repeat16", int'(timer_seconds), 16);
        repeat (85) rpt();
        chk("sat_max", int'(timer_seconds), 99);
        inc_btn = 1'b0; step();
        press(3);
        press(1);
        chk("sat_zero", int'(timer_seconds), 0);

        // pause behaviour
        repeat (5) press(0);
        press(2);
        sec(); sec();
        press(2);
        chk("pause_state", int'(state), 2);
        repeat (4) sec();
        chk("pause_count", int'(timer_seconds), 3);
        repeat (3) press(1);
        chk("pause_floor", int'(timer_seconds), 1);
        press(2);
        tick_1hz = 1'b1; step();
        chk("resume_done", int'(state), 3);
        tick_1hz = 1'b0; step();
        press(0);
        chk("ack_count", int'(timer_seconds), 5);
        chk("ack_state", int'(state), 0);

        // start at zero, start with clear
        press(3);
        press(2);
        chk("start_zero", int'(state), 0);
        repeat (2) press(0);
        press(2);
        start_btn = 1'b1; clr_btn = 1'b1; step();
        chk("clr_state", int'(state), 0);
        chk("clr_count", int'(timer_seconds), 0);
        start_btn = 1'b0; clr_btn = 1'b0; step();

        // tick and start together at count 1
        press(0);
        press(2);
        tick_1hz = 1'b1; start_btn = 1'b1; step();
        chk("tick_start_state", int'(state), 3);
        chk("tick_start_pulse", int'(done_pulse), 1);
        tick_1hz = 1'b0; start_btn = 1'b0; step();
        press(3);

        // timer_mode abort
        repeat (7) press(0);
        press(2);
        timer_mode = 1'b0; step();
        chk("abort_state", int'(state), 0);
        chk("abort_count", int'(timer_seconds), 0);
        chk("abort_pulse", int'(done_pulse), 0);
        timer_mode = 1'b1; step();

        // reset during DONE
        repeat (2) press(0);
        press(2);
        sec(); sec();
        chk("pre_rst_alarm", int'(alarm), 1);
        rst = 1'b1; step();
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_state2", int'(state), 0);
        rst = 1'b0; step();

        // random phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0)  inc_btn   = ~inc_btn;
            if ($urandom_range(0, 13) == 0)  dec_btn   = ~dec_btn;
            if ($urandom_range(0, 19) == 0)  start_btn = ~start_btn;
            clr_btn    = ($urandom_range(0, 249) == 0);
            tick_1hz   = ($urandom_range(0, 5) == 0) && !tick_1hz;
            tick_rpt   = ($urandom_range(0, 2) == 0);
            timer_mode = ($urandom_range(0, 399) != 0);
            rst        = ($urandom_range(0, 1499) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
